decrypt_word_packer: RTL and testbench

Packs the decrypted byte stream (8-bit data plus valid strobe from the decrypt stage) into 32-bit little-endian words and buffers them in a show-ahead FIFO, which a valid/ready consumer drains. The decrypt stage has no backpressure, so this block absorbs rate mismatch and reports lost words through a sticky overflow flag. A flush input closes out a partially filled word at end of message.

---
 rtl/decrypt_word_packer.sv | 117 +++++++++++
 tb/tb_decrypt_word_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decrypt_word_packer.sv
// Packs a decrypted byte stream into 32-bit little-endian words and queues them
// in a show-ahead FIFO with a sticky overflow flag for words lost while full.
module decrypt_word_packer #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_v,
    input  logic             flush,
    input  logic             clr_ovf,
    output logic [31:0]      out_data,
    output logic [2:0]       out_bytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [23:0]   lanes_reg;
    logic [1:0]    cnt_reg;
    logic [31:0]   merged;
    logic          wr_req;
    logic [2:0]    wr_bytes;
    logic          wr_ok;
    logic          rd_en;
    logic          full;
    logic          ovf_set;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic          ovf_reg;
    logic [34:0]   mem [DEPTH];
    logic [34:0]   head;

    // Incoming byte lands in lane cnt; the other lanes keep their stored bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_stored
                assign merged[gi*8 +: 8] = (din_v && cnt_reg == 2'(gi)) ? din
                                                                         : lanes_reg[gi*8 +: 8];
            end else begin : g_top
                assign merged[gi*8 +: 8] = (din_v && cnt_reg == 2'd3) ? din : 8'h00;
            end
        end
    endgenerate

    always_comb begin
        wr_req   = 1'b0;
        wr_bytes = 3'd0;
        if (din_v) begin
            wr_req   = (cnt_reg == 2'd3) || flush;
            wr_bytes = 3'({1'b0, cnt_reg}) + 3'd1;
        end else begin
            wr_req   = flush && (cnt_reg != 2'd0);
            wr_bytes = 3'({1'b0, cnt_reg});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes_reg <= '0;
            cnt_reg   <= '0;
        end else if (wr_req) begin
            // Lanes are cleared even when the word is dropped on overflow.
            lanes_reg <= '0;
            cnt_reg   <= '0;
        end else if (din_v) begin
            lanes_reg <= merged[23:0];
            cnt_reg   <= cnt_reg + 2'd1;
        end
    end

    assign out_valid = (wr_ptr_reg != rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_en     = out_valid && out_ready;
    assign wr_ok     = wr_req && (!full || rd_en);
    assign ovf_set   = wr_req && full && !rd_en;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= {wr_bytes, merged};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Head entry is masked when empty so stale RAM contents never show.
    assign head      = mem[rd_ptr_reg[AW-1:0]];
    assign out_data  = out_valid ? head[31:0]  : 32'h0;
    assign out_bytes = out_valid ? head[34:32] : 3'd0;
    assign level     = LVL_W'(wr_ptr_reg - rd_ptr_reg);
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_decrypt_word_packer.sv
// Directed and random stimulus for decrypt_word_packer, checked every cycle
// against a queue-based model of packing, FIFO occupancy and overflow.
module tb_decrypt_word_packer;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       din = '0;
    logic             din_v = 1'b0;
    logic             flush = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [31:0]      out_data;
    logic [2:0]       out_bytes;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [LVL_W-1:0] level;
    logic             overflow;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [7:0]  m_pend[$];
    logic [34:0] m_fifo[$];
    logic        m_ovf = 1'b0;

    decrypt_word_packer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_v(din_v), .flush(flush),
        .clr_ovf(clr_ovf), .out_data(out_data), .out_bytes(out_bytes),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge: pop, gather the byte, emit a word, push or drop.
    task automatic model_step();
        logic [31:0] w;
        bit rd;
        bit drop;
        rd = (m_fifo.size() > 0) && out_ready;
        drop = 1'b0;
        if (rd) void'(m_fifo.pop_front());
        if (din_v) m_pend.push_back(din);
        if (m_pend.size() == 4 || (flush && m_pend.size() > 0)) begin
            w = 32'h0;
            foreach (m_pend[i]) w[i*8 +: 8] = m_pend[i];
            if (m_fifo.size() < DEPTH) m_fifo.push_back({3'(m_pend.size()), w});
            else drop = 1'b1;
            m_pend.delete();
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic cycle(input logic [7:0] d, input logic v, input logic f,
                         input logic c, input logic r);
        din = d; din_v = v; flush = f; clr_ovf = c; out_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        din_v = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
            chk("level", 64'(level), 64'(m_fifo.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (m_fifo.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(m_fifo[0][31:0]));
                chk("out_bytes", 64'(out_bytes), 64'(m_fifo[0][34:32]));
            end else begin
                chk("out_data_empty", 64'(out_data), 64'h0);
                chk("out_bytes_empty", 64'(out_bytes), 64'h0);
            end
        end
    end

    initial begin
        int sent;
        logic [7:0] rb;
        logic rv, rr, rf;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Full word with consumer ready.
        cycle(8'h11, 1, 0, 0, 1);
        cycle(8'h22, 1, 0, 0, 1);
        cycle(8'h33, 1, 0, 0, 1);
        cycle(8'h44, 1, 0, 0, 1);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_data", 64'(out_data), 64'h44332211);
        chk("t1_bytes", 64'(out_bytes), 64'h4);
        cycle(8'h00, 0, 0, 0, 1);
        chk("t1_level_after_pop", 64'(level), 64'h0);

        // Flush of a partial word, then flush together with the third byte.
        cycle(8'hAA, 1, 0, 0, 0);
        cycle(8'hBB, 1, 0, 0, 0);
        cycle(8'h00, 0, 1, 0, 0);
        chk("t2_data", 64'(out_data), 64'h0000BBAA);
        chk("t2_bytes", 64'(out_bytes), 64'h2);
        cycle(8'h01, 1, 0, 0, 1);
        cycle(8'h02, 1, 0, 0, 0);
        cycle(8'hCC, 1, 1, 0, 0);
        chk("t3_data", 64'(out_data), 64'h00CC0201);
        chk("t3_bytes", 64'(out_bytes), 64'h3);
        chk("t3_level", 64'(level), 64'h1);
        cycle(8'h00, 0, 0, 0, 1);
        cycle(8'h00, 0, 1, 0, 0);
        chk("t4_idle_flush_level", 64'(level), 64'h0);

        // Fill the FIFO, overflow, clear, and set-wins-over-clear.
        for (int k = 0; k < 4 * DEPTH; k++) cycle(8'(k), 1, 0, 0, 0);
        chk("t5_full_level", 64'(level), 64'(DEPTH));
        chk("t5_full_ovf", 64'(overflow), 64'h0);
        for (int k = 0; k < 4; k++) cycle(8'hE0 + 8'(k), 1, 0, 0, 0);
        chk("t5_ovf_set", 64'(overflow), 64'h1);
        chk("t5_ovf_level", 64'(level), 64'(DEPTH));
        chk("t5_head_kept", 64'(out_data), 64'h03020100);
        cycle(8'h00, 0, 0, 1, 0);
        chk("t5_ovf_clr", 64'(overflow), 64'h0);
        for (int k = 0; k < 3; k++) cycle(8'hF0 + 8'(k), 1, 0, 0, 0);
        cycle(8'hF3, 1, 0, 1, 0);
        chk("t5_set_wins", 64'(overflow), 64'h1);
        cycle(8'h00, 0, 0, 1, 0);

        // Full FIFO, last byte arrives with a read: both happen.
        for (int k = 0; k < 3; k++) cycle(8'hA0 + 8'(k), 1, 0, 0, 0);
        cycle(8'hA3, 1, 0, 0, 1);
        chk("t6_level", 64'(level), 64'(DEPTH));
        chk("t6_ovf", 64'(overflow), 64'h0);
        chk("t6_new_head", 64'(out_data), 64'h07060504);
        repeat (DEPTH + 1) cycle(8'h00, 0, 0, 0, 1);
        chk("t6_drained", 64'(level), 64'h0);

        // Random traffic over 1000 bytes.
        sent = 0;
        while (sent < 1000) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 9) < 7);
            rf = ($urandom_range(0, 15) == 0);
            rb = 8'($urandom);
            cycle(rb, rv, rf, 1'b0, rr);
            if (rv) sent++;
        end
        cycle(8'h00, 0, 1, 1, 1);
        repeat (DEPTH + 2) cycle(8'h00, 0, 0, 0, 1);
        chk("t7_drained", 64'(level), 64'h0);

        // Asynchronous reset mid-word with two words queued.
        for (int k = 0; k < 10; k++) cycle(8'h50 + 8'(k), 1, 0, 0, 0);
        chk("t8_level_before", 64'(level), 64'h2);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t8_rst_valid", 64'(out_valid), 64'h0);
        chk("t8_rst_data", 64'(out_data), 64'h0);
        chk("t8_rst_bytes", 64'(out_bytes), 64'h0);
        chk("t8_rst_level", 64'(level), 64'h0);
        chk("t8_rst_ovf", 64'(overflow), 64'h0);
        m_fifo.delete();
        m_pend.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        cycle(8'hD1, 1, 0, 0, 0);
        cycle(8'hD2, 1, 0, 0, 0);
        cycle(8'hD3, 1, 0, 0, 0);
        cycle(8'hD4, 1, 0, 0, 0);
        chk("t8_clean_data", 64'(out_data), 64'hD4D3D2D1);
        chk("t8_clean_bytes", 64'(out_bytes), 64'h4);
        chk("t8_clean_level", 64'(level), 64'h1);
        cycle(8'h00, 0, 0, 0, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
